// File: rtl/operand_stack.sv
// LIFO operand stack answering the stk_push/stk_pop/stk_data bus.
// Pops return data one cycle later through a registered output; errors are sticky.
module operand_stack #(
    parameter int DATA_LEN = 8,
    parameter int DEPTH    = 16,
    parameter int ADDR_LEN = 4
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                stk_push,
    input  logic                stk_pop,
    input  logic [DATA_LEN-1:0] stk_data_in,
    output logic [DATA_LEN-1:0] stk_data_out,
    input  logic                stk_clr,
    input  logic                err_clr,
    output logic [ADDR_LEN:0]   count,
    output logic                empty,
    output logic                full,
    output logic                ovf_err,
    output logic                unf_err
);

    localparam logic [ADDR_LEN:0] DEPTH_C = (ADDR_LEN+1)'(DEPTH);

    logic [DATA_LEN-1:0] mem_q [DEPTH];
    logic [ADDR_LEN:0]   sp_q, sp_d;
    logic [DATA_LEN-1:0] dout_q, dout_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;

    logic                we;
    logic [ADDR_LEN-1:0] waddr;
    logic [ADDR_LEN:0]   sp_m1;
    logic [ADDR_LEN-1:0] top;
    logic                push_only, pop_only, swap;

    assign count = sp_q;
    assign empty = (sp_q == '0);
    assign full  = (sp_q == DEPTH_C);

    assign stk_data_out = dout_q;
    assign ovf_err      = ovf_q;
    assign unf_err      = unf_q;

    assign sp_m1 = sp_q - 1'b1;
    assign top   = sp_m1[ADDR_LEN-1:0];

    // Pulled-down bus lines: only a driven 1 counts as a request.
    assign push_only = stk_push && !stk_pop;
    assign pop_only  = stk_pop && !stk_push;
    assign swap      = stk_push && stk_pop;

    always_comb begin
        sp_d   = sp_q;
        dout_d = dout_q;
        ovf_d  = ovf_q;
        unf_d  = unf_q;
        we     = 1'b0;
        waddr  = '0;

        // Clearing first lets an error raised this cycle overwrite it below.
        if (err_clr) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end

        if (stk_clr) begin
            sp_d   = '0;
            dout_d = '0;
        end else if (push_only) begin
            if (!full) begin
                we    = 1'b1;
                waddr = sp_q[ADDR_LEN-1:0];
                sp_d  = sp_q + 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (pop_only) begin
            if (!empty) begin
                dout_d = mem_q[top];
                sp_d   = sp_m1;
            end else begin
                dout_d = '0;
                unf_d  = 1'b1;
            end
        end else if (swap) begin
            if (!empty) begin
                dout_d = mem_q[top];
                we     = 1'b1;
                waddr  = top;
            end else begin
                // Swap on an empty stack still lands the pushed value.
                dout_d = '0;
                unf_d  = 1'b1;
                we     = 1'b1;
                waddr  = '0;
                sp_d   = (ADDR_LEN+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sp_q   <= '0;
            dout_q <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            sp_q   <= sp_d;
            dout_q <= dout_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= stk_data_in;
    end

endmodule

// File: tb/tb_operand_stack.sv
// Directed checks of operand_stack: reset, LIFO order, full/overflow, underflow, swap, clear.
module tb_operand_stack;

    logic       clk = 1'b0;
    logic       rstn;
    logic       stk_push, stk_pop, stk_clr, err_clr;
    logic [7:0] stk_data_in, stk_data_out;
    logic [4:0] count;
    logic       empty, full, ovf_err, unf_err;

    int n_cmp = 0;
    int n_err = 0;

    operand_stack #(.DATA_LEN(8), .DEPTH(16), .ADDR_LEN(4)) dut (
        .clk(clk), .rstn(rstn),
        .stk_push(stk_push), .stk_pop(stk_pop),
        .stk_data_in(stk_data_in), .stk_data_out(stk_data_out),
        .stk_clr(stk_clr), .err_clr(err_clr),
        .count(count), .empty(empty), .full(full),
        .ovf_err(ovf_err), .unf_err(unf_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive, take the edge, sample 1ns later, return to idle.
    task automatic op(input logic p, input logic q, input logic [7:0] d,
                      input logic c, input logic e);
        stk_push = p; stk_pop = q; stk_data_in = d; stk_clr = c; err_clr = e;
        @(posedge clk);
        #1;
        stk_push = 1'b0; stk_pop = 1'b0; stk_clr = 1'b0; err_clr = 1'b0;
    endtask

    task automatic reset_pulse();
        #2 rstn = 1'b0;
        #1;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full",  full, 0);
        chk("rst_dout",  stk_data_out, 0);
        chk("rst_ovf",   ovf_err, 0);
        chk("rst_unf",   unf_err, 0);
        #1 rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b0; stk_push = 1'b0; stk_pop = 1'b0; stk_clr = 1'b0; err_clr = 1'b0;
        stk_data_in = '0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;

        // 1. dirty the state, then async reset mid-cycle
        op(0, 1, 8'h00, 0, 0);
        chk("pre_unf", unf_err, 1);
        op(1, 0, 8'hAA, 0, 0);
        op(1, 0, 8'hBB, 0, 0);
        op(0, 1, 8'h00, 0, 0);
        chk("pre_dout", stk_data_out, 8'hBB);
        chk("pre_count", count, 1);
        reset_pulse();

        // 2. LIFO order
        op(1, 0, 8'h05, 0, 0);
        op(1, 0, 8'h03, 0, 0);
        chk("lifo_count2", count, 2);
        op(0, 1, 8'h00, 0, 0);
        chk("lifo_pop1", stk_data_out, 8'h03);
        chk("lifo_count1", count, 1);
        op(0, 0, 8'h00, 0, 0);
        chk("lifo_hold", stk_data_out, 8'h03);
        op(0, 1, 8'h00, 0, 0);
        chk("lifo_pop2", stk_data_out, 8'h05);
        chk("lifo_count0", count, 0);
        chk("lifo_empty", empty, 1);

        // 3. fill, overflow, pop top
        for (int i = 0; i < 16; i++) op(1, 0, 8'(i), 0, 0);
        chk("full_flag", full, 1);
        chk("full_count", count, 16);
        chk("full_ovf0", ovf_err, 0);
        op(1, 0, 8'hAA, 0, 0);
        chk("ovf_flag", ovf_err, 1);
        chk("ovf_count", count, 16);
        op(0, 1, 8'h00, 0, 0);
        chk("ovf_pop", stk_data_out, 8'h0F);
        chk("ovf_count15", count, 15);
        op(0, 0, 8'h00, 0, 1);
        chk("ovf_clr", ovf_err, 0);
        op(0, 0, 8'h00, 1, 0);
        chk("fill_clr_count", count, 0);

        // 4. underflow
        op(1, 0, 8'h42, 0, 0);
        op(0, 1, 8'h00, 0, 0);
        chk("unf_pre_dout", stk_data_out, 8'h42);
        op(0, 1, 8'h00, 0, 0);
        chk("unf_dout", stk_data_out, 0);
        chk("unf_flag", unf_err, 1);
        chk("unf_count", count, 0);
        op(0, 0, 8'h00, 0, 1);
        chk("unf_clr", unf_err, 0);
        op(0, 1, 8'h00, 0, 1);
        chk("unf_clr_vs_new", unf_err, 1);

        // 5. swap
        op(0, 0, 8'h00, 0, 1);
        op(1, 0, 8'h11, 0, 0);
        op(1, 1, 8'h22, 0, 0);
        chk("swap_dout", stk_data_out, 8'h11);
        chk("swap_count", count, 1);
        chk("swap_unf", unf_err, 0);
        op(0, 1, 8'h00, 0, 0);
        chk("swap_pop", stk_data_out, 8'h22);
        chk("swap_empty", empty, 1);
        op(1, 1, 8'h33, 0, 0);
        chk("swap_e_dout", stk_data_out, 0);
        chk("swap_e_unf", unf_err, 1);
        chk("swap_e_count", count, 1);
        op(0, 1, 8'h00, 0, 0);
        chk("swap_e_pop", stk_data_out, 8'h33);

        // 6a. clear mid-use with a push in the same cycle
        for (int i = 0; i < 3; i++) op(1, 0, 8'(8'h60 + i), 0, 0);
        op(1, 0, 8'h99, 1, 0);
        chk("clr_count", count, 0);
        chk("clr_dout", stk_data_out, 0);
        chk("clr_keeps_unf", unf_err, 1);
        op(1, 0, 8'h7F, 0, 0);
        op(0, 1, 8'h00, 0, 0);
        chk("clr_pop", stk_data_out, 8'h7F);
        chk("clr_empty", empty, 1);

        // 6b. same with reset
        for (int i = 0; i < 3; i++) op(1, 0, 8'(8'h50 + i), 0, 0);
        op(0, 1, 8'h00, 0, 0);
        chk("rst2_pre", stk_data_out, 8'h52);
        reset_pulse();
        op(1, 0, 8'h7F, 0, 0);
        op(0, 1, 8'h00, 0, 0);
        chk("rst2_pop", stk_data_out, 8'h7F);
        chk("rst2_empty", empty, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
